// File: rtl/z80_io_port_bank.sv
// Z80 I/O port bank: windowed decode of NUM_PORTS consecutive I/O ports,
// strobe synchronisation, transceiver control and per-port mailboxes.
module z80_io_port_bank #(
  parameter logic [15:0] BASE_ADDR   = 16'h0030,
  parameter int          NUM_PORTS   = 4,
  parameter int          ADDR_BITS   = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            z80_a,
  input  logic [7:0]             z80_d_in,
  output logic [7:0]             z80_d_out,
  output logic                   z80_d_oe,
  output logic                   z80_d_dir,
  input  logic                   z80_rd_n,
  input  logic                   z80_wr_n,
  input  logic                   z80_m1_n,
  input  logic                   z80_iorq_n,
  input  logic                   z80_mreq_n,
  input  logic [8*NUM_PORTS-1:0] host_tx_data,
  output logic [8*NUM_PORTS-1:0] host_rx_data,
  output logic [NUM_PORTS-1:0]   rd_pulse,
  output logic [NUM_PORTS-1:0]   wr_pulse,
  output logic [NUM_PORTS-1:0]   rx_full,
  input  logic [NUM_PORTS-1:0]   rx_ack,
  output logic [NUM_PORTS-1:0]   overrun
);

  localparam int IW =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_BITS-1:0] BASE =
    BASE_ADDR[ADDR_BITS-1:0];
  localparam logic [ADDR_BITS-1:0] SPAN =
    ADDR_BITS'(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE,
    RD_DRIVE,
    WR_CAP,
    WR_HOLD
  } state_t;

  logic [SYNC_STAGES-1:0] rd_s_q;
  logic [SYNC_STAGES-1:0] wr_s_q;
  logic [SYNC_STAGES-1:0] m1_s_q;
  logic [SYNC_STAGES-1:0] iorq_s_q;
  logic [SYNC_STAGES-1:0] mreq_s_q;

  logic rd_s, wr_s, m1_s, iorq_s, mreq_s;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [7:0]             dout_q, dout_d;
  logic                   oe_q, oe_d;
  logic                   dir_q, dir_d;
  logic [8*NUM_PORTS-1:0] rx_q, rx_d;
  logic [NUM_PORTS-1:0]   rdp_q, rdp_d;
  logic [NUM_PORTS-1:0]   wrp_q, wrp_d;
  logic [NUM_PORTS-1:0]   full_q, full_d;
  logic [NUM_PORTS-1:0]   ovr_q, ovr_d;

  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] off;
  logic [IW-1:0]        idx;
  logic                 in_win;
  logic                 io_ok;
  logic                 rd_hit;
  logic                 wr_hit;

  // Chains preset high so a reset never looks like an active strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_s_q   <= '1;
      wr_s_q   <= '1;
      m1_s_q   <= '1;
      iorq_s_q <= '1;
      mreq_s_q <= '1;
    end else begin
      rd_s_q   <= {rd_s_q[SYNC_STAGES-2:0], z80_rd_n};
      wr_s_q   <= {wr_s_q[SYNC_STAGES-2:0], z80_wr_n};
      m1_s_q   <= {m1_s_q[SYNC_STAGES-2:0], z80_m1_n};
      iorq_s_q <= {iorq_s_q[SYNC_STAGES-2:0], z80_iorq_n};
      mreq_s_q <= {mreq_s_q[SYNC_STAGES-2:0], z80_mreq_n};
    end
  end

  assign rd_s   = rd_s_q[SYNC_STAGES-1];
  assign wr_s   = wr_s_q[SYNC_STAGES-1];
  assign m1_s   = m1_s_q[SYNC_STAGES-1];
  assign iorq_s = iorq_s_q[SYNC_STAGES-1];
  assign mreq_s = mreq_s_q[SYNC_STAGES-1];

  // addr >= BASE guarantees the offset never wraps
  assign addr   = z80_a[ADDR_BITS-1:0];
  assign off    = addr - BASE;
  assign in_win = (addr >= BASE) && (off < SPAN);
  assign idx    = off[IW-1:0];

  assign io_ok  = ~iorq_s & mreq_s & m1_s;
  assign rd_hit = io_ok & in_win & ~rd_s & wr_s;
  assign wr_hit = io_ok & in_win & rd_s & ~wr_s;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    dir_d   = dir_q;
    rx_d    = rx_q;
    rdp_d   = '0;
    wrp_d   = '0;
    full_d  = full_q & ~rx_ack;
    ovr_d   = ovr_q & ~rx_ack;
    unique case (state_q)
      IDLE: begin
        if (rd_hit) begin
          state_d    = RD_DRIVE;
          idx_d      = idx;
          dout_d     = host_tx_data[idx*8 +: 8];
          dir_d      = 1'b0;
          oe_d       = 1'b1;
          rdp_d[idx] = 1'b1;
        end else if (wr_hit) begin
          state_d = WR_CAP;
          idx_d   = idx;
          oe_d    = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (rd_s | iorq_s) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          dir_d   = 1'b1;
        end
      end
      WR_CAP: begin
        state_d              = WR_HOLD;
        rx_d[idx_q*8 +: 8]   = z80_d_in;
        wrp_d[idx_q]         = 1'b1;
        full_d[idx_q]        = 1'b1;
        // A coinciding ack means the old byte was taken: no overrun
        ovr_d[idx_q]         = (ovr_q[idx_q] | full_q[idx_q])
                             & ~rx_ack[idx_q];
      end
      WR_HOLD: begin
        if (wr_s | iorq_s) begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      dir_q   <= 1'b1;
      rx_q    <= '0;
      rdp_q   <= '0;
      wrp_q   <= '0;
      full_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      dir_q   <= dir_d;
      rx_q    <= rx_d;
      rdp_q   <= rdp_d;
      wrp_q   <= wrp_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
    end
  end

  assign z80_d_out    = dout_q;
  assign z80_d_oe     = oe_q;
  assign z80_d_dir    = dir_q;
  assign host_rx_data = rx_q;
  assign rd_pulse     = rdp_q;
  assign wr_pulse     = wrp_q;
  assign rx_full      = full_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_z80_io_port_bank.sv
// Bench for z80_io_port_bank: 16-bit and 8-bit decode instances on one
// shared Z80 bus, vector table, directed corners and random cycles.
module tb_z80_io_port_bank;

  localparam int NP = 4;
  localparam int HOLD = 8;
  localparam int REL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [15:0]   z80_a;
  logic [7:0]    z80_d_in;
  logic          rd_n, wr_n, m1_n, iorq_n, mreq_n;
  logic [8*NP-1:0] tx;
  logic [NP-1:0] ack   [2];
  logic [7:0]    dout  [2];
  logic          oe    [2];
  logic          dir   [2];
  logic [8*NP-1:0] rxd [2];
  logic [NP-1:0] rdp   [2];
  logic [NP-1:0] wrp   [2];
  logic [NP-1:0] full  [2];
  logic [NP-1:0] ovr   [2];

  int checks = 0;
  int errors = 0;

  z80_io_port_bank #(
    .BASE_ADDR(16'h0030), .NUM_PORTS(NP),
    .ADDR_BITS(16), .SYNC_STAGES(2)
  ) dut16 (
    .clk(clk), .rst(rst), .z80_a(z80_a),
    .z80_d_in(z80_d_in), .z80_d_out(dout[0]),
    .z80_d_oe(oe[0]), .z80_d_dir(dir[0]),
    .z80_rd_n(rd_n), .z80_wr_n(wr_n),
    .z80_m1_n(m1_n), .z80_iorq_n(iorq_n),
    .z80_mreq_n(mreq_n), .host_tx_data(tx),
    .host_rx_data(rxd[0]), .rd_pulse(rdp[0]),
    .wr_pulse(wrp[0]), .rx_full(full[0]),
    .rx_ack(ack[0]), .overrun(ovr[0])
  );

  z80_io_port_bank #(
    .BASE_ADDR(16'h0030), .NUM_PORTS(NP),
    .ADDR_BITS(8), .SYNC_STAGES(2)
  ) dut8 (
    .clk(clk), .rst(rst), .z80_a(z80_a),
    .z80_d_in(z80_d_in), .z80_d_out(dout[1]),
    .z80_d_oe(oe[1]), .z80_d_dir(dir[1]),
    .z80_rd_n(rd_n), .z80_wr_n(wr_n),
    .z80_m1_n(m1_n), .z80_iorq_n(iorq_n),
    .z80_mreq_n(mreq_n), .host_tx_data(tx),
    .host_rx_data(rxd[1]), .rd_pulse(rdp[1]),
    .wr_pulse(wrp[1]), .rx_full(full[1]),
    .rx_ack(ack[1]), .overrun(ovr[1])
  );

  // Mailbox reference model
  logic [7:0] m_data [2][NP];
  bit         m_full [2][NP];
  bit         m_ovr  [2][NP];

  // Per-cycle observations
  bit         oe_seen [2];
  int         dir0_first [2];
  int         dir0_n [2];
  int         dout_bad [2];
  logic [7:0] dout_first [2];
  int         rdcnt [2][NP];
  int         wrcnt [2][NP];
  int         rel_dir [2];
  int         rel_oe [2];

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    bit          m1l;
    bit          mql;
    bit          both;
    int          e16;
    int          e8;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic int port_of(input int n,
                                 input logic [15:0] a);
    int ad;
    ad = (n == 0) ? int'(a) : int'(a[7:0]);
    if (ad >= 48 && ad < 48 + NP) return ad - 48;
    return -1;
  endfunction

  function automatic int hit_port(input int n,
                                  input logic [15:0] a,
                                  input bit m1l,
                                  input bit mql,
                                  input bit both);
    if (m1l || mql || both) return -1;
    return port_of(n, a);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < NP; k++) begin
        m_data[n][k] = 8'h00;
        m_full[n][k] = 1'b0;
        m_ovr[n][k]  = 1'b0;
      end
  endtask

  task automatic check_mbox(input string tag);
    logic [8*NP-1:0] ed;
    logic [NP-1:0]   ef, eo;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < NP; k++) begin
        ed[k*8 +: 8] = m_data[n][k];
        ef[k] = m_full[n][k];
        eo[k] = m_ovr[n][k];
      end
      chk($sformatf("%s/%0d rx_data", tag, n), rxd[n], ed);
      chk($sformatf("%s/%0d rx_full", tag, n), full[n], ef);
      chk($sformatf("%s/%0d overrun", tag, n), ovr[n], eo);
    end
  endtask

  task automatic sample(input int t, input bit rel);
    for (int n = 0; n < 2; n++) begin
      if (oe[n]) oe_seen[n] = 1'b1;
      if (!dir[n]) begin
        if (dir0_n[n] == 0) begin
          dir0_first[n] = t;
          dout_first[n] = dout[n];
        end else if (dout[n] !== dout_first[n]) begin
          dout_bad[n]++;
        end
        dir0_n[n]++;
      end
      for (int k = 0; k < NP; k++) begin
        rdcnt[n][k] += int'(rdp[n][k]);
        wrcnt[n][k] += int'(wrp[n][k]);
      end
      if (rel) begin
        if (dir[n] && rel_dir[n] < 0 && dir0_n[n] > 0)
          rel_dir[n] = t;
        if (!oe[n] && rel_oe[n] < 0) rel_oe[n] = t;
      end
    end
  endtask

  task automatic ack_ports(input logic [NP-1:0] a0,
                           input logic [NP-1:0] a1);
    ack[0] = a0;
    ack[1] = a1;
    @(posedge clk); #1;
    ack[0] = '0;
    ack[1] = '0;
    for (int k = 0; k < NP; k++) begin
      if (a0[k]) begin m_full[0][k] = 0; m_ovr[0][k] = 0; end
      if (a1[k]) begin m_full[1][k] = 0; m_ovr[1][k] = 0; end
    end
  endtask

  // One Z80 I/O cycle; e0/e1 are the expected ports (-1 = none).
  // ackm is applied to the 16-bit instance on edge ack_edge.
  task automatic bus_op(input string tag,
                        input bit wr,
                        input logic [15:0] a,
                        input logic [7:0] d,
                        input bit m1l,
                        input bit mql,
                        input bit both,
                        input int e0,
                        input int e1,
                        input logic [NP-1:0] ackm,
                        input int ack_edge);
    int e [2];
    longint obs, expv;
    e[0] = e0;
    e[1] = e1;
    for (int n = 0; n < 2; n++) begin
      oe_seen[n] = 0; dir0_first[n] = -1; dir0_n[n] = 0;
      dout_bad[n] = 0; dout_first[n] = 8'h00;
      rel_dir[n] = -1; rel_oe[n] = -1;
      for (int k = 0; k < NP; k++) begin
        rdcnt[n][k] = 0;
        wrcnt[n][k] = 0;
      end
    end
    z80_a    = a;
    z80_d_in = d;
    mreq_n   = ~mql;
    m1_n     = ~m1l;
    iorq_n   = 1'b0;
    rd_n     = both ? 1'b0 : wr;
    wr_n     = both ? 1'b0 : ~wr;
    for (int i = 1; i <= HOLD; i++) begin
      ack[0] = (i == ack_edge) ? ackm : '0;
      @(posedge clk); #1;
      sample(i, 1'b0);
    end
    ack[0] = '0;
    rd_n = 1'b1; wr_n = 1'b1; iorq_n = 1'b1;
    m1_n = 1'b1; mreq_n = 1'b1;
    for (int j = 1; j <= REL; j++) begin
      @(posedge clk); #1;
      sample(j, 1'b1);
    end
    for (int n = 0; n < 2; n++) begin
      string t;
      int p;
      t = $sformatf("%s/%0d", tag, n);
      p = e[n];
      chk({t, " oe_seen"}, oe_seen[n], p >= 0);
      obs = 0;
      for (int k = 0; k < NP; k++)
        obs += longint'(rdcnt[n][k]) << (4 * k);
      expv = (p >= 0 && !wr) ? (64'd1 << (4 * p)) : 0;
      chk({t, " rd_pulse"}, obs, expv);
      obs = 0;
      for (int k = 0; k < NP; k++)
        obs += longint'(wrcnt[n][k]) << (4 * k);
      expv = (p >= 0 && wr) ? (64'd1 << (4 * p)) : 0;
      chk({t, " wr_pulse"}, obs, expv);
      if (p >= 0 && !wr) begin
        chk({t, " dir_latency"}, dir0_first[n], 3);
        chk({t, " d_out"}, dout_first[n], tx[p*8 +: 8]);
        chk({t, " d_out_hold"}, dout_bad[n], 0);
        chk({t, " dir_release"}, rel_dir[n], 3);
      end else begin
        chk({t, " no_dir0"}, dir0_n[n], 0);
      end
      if (p >= 0) chk({t, " oe_release"}, rel_oe[n], 3);
      if (n == 0 && ack_edge > 0)
        for (int k = 0; k < NP; k++)
          if (ackm[k] && !(wr && k == p)) begin
            m_full[0][k] = 0;
            m_ovr[0][k]  = 0;
          end
      if (p >= 0 && wr) begin
        if (n == 0 && ack_edge == 4 && ackm[p])
          m_ovr[n][p] = 1'b0;
        else
          m_ovr[n][p] = m_ovr[n][p] | m_full[n][p];
        m_full[n][p] = 1'b1;
        m_data[n][p] = d;
      end
    end
    check_mbox(tag);
  endtask

  // dir low must always coincide with the bus being driven
  always @(negedge clk) begin
    if (!rst) begin
      for (int n = 0; n < 2; n++) begin
        if (!dir[n]) begin
          checks++;
          if (!oe[n]) begin
            errors++;
            $display("FAIL dir_inv/%0d: dir=0 with oe=0", n);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    z80_a = 16'h0000; z80_d_in = 8'h00;
    rd_n = 1; wr_n = 1; m1_n = 1; iorq_n = 1; mreq_n = 1;
    tx = {8'h44, 8'hA5, 8'h22, 8'h11};
    ack[0] = '0; ack[1] = '0;
    model_reset();

    tbl[0]  = '{0, 16'h0032, 8'h00, 0, 0, 0,  2,  2};
    tbl[1]  = '{1, 16'h0031, 8'h3C, 0, 0, 0,  1,  1};
    tbl[2]  = '{1, 16'h0031, 8'h7E, 0, 0, 0,  1,  1};
    tbl[3]  = '{0, 16'h002F, 8'h00, 0, 0, 0, -1, -1};
    tbl[4]  = '{0, 16'h0034, 8'h00, 0, 0, 0, -1, -1};
    tbl[5]  = '{0, 16'h1230, 8'h00, 0, 0, 0, -1,  0};
    tbl[6]  = '{1, 16'h1233, 8'hC3, 0, 0, 0, -1,  3};
    tbl[7]  = '{0, 16'h0030, 8'h00, 1, 0, 0, -1, -1};
    tbl[8]  = '{0, 16'h0030, 8'h00, 0, 0, 1, -1, -1};
    tbl[9]  = '{1, 16'h0030, 8'h99, 0, 1, 0, -1, -1};
    tbl[10] = '{0, 16'h0033, 8'h00, 0, 0, 0,  3,  3};
    tbl[11] = '{1, 16'h0030, 8'h55, 0, 0, 0,  0,  0};

    #1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("rst/%0d oe", n), oe[n], 0);
      chk($sformatf("rst/%0d dir", n), dir[n], 1);
      chk($sformatf("rst/%0d d_out", n), dout[n], 0);
      chk($sformatf("rst/%0d pulses", n),
          {rdp[n], wrp[n]}, 0);
    end
    check_mbox("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("idle/%0d oe", n), oe[n], 0);
      chk($sformatf("idle/%0d dir", n), dir[n], 1);
      chk($sformatf("idle/%0d pulses", n),
          {rdp[n], wrp[n]}, 0);
    end
    check_mbox("idle");

    for (int i = 0; i < 12; i++) begin
      bus_op($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].a,
             tbl[i].d, tbl[i].m1l, tbl[i].mql, tbl[i].both,
             tbl[i].e16, tbl[i].e8, '0, 0);
      if (i == 2) begin
        chk("ovr1 set", ovr[0][1], 1);
        chk("ovr1 data", rxd[0][15:8], 8'h7E);
      end
    end

    ack_ports(4'b0010, 4'b0010);
    chk("ack1 full", full[0][1], 0);
    chk("ack1 ovr", ovr[0][1], 0);
    check_mbox("ack1");

    // Reset while the read is being driven
    z80_a = 16'h0032; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst dir", dir[0], 0);
    #2 rst = 1'b1;
    #1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("async_rst/%0d dir", n), dir[n], 1);
      chk($sformatf("async_rst/%0d oe", n), oe[n], 0);
      chk($sformatf("async_rst/%0d d_out", n), dout[n], 0);
    end
    rd_n = 1'b1; iorq_n = 1'b1;
    model_reset();
    check_mbox("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ack on the capture edge of a full mailbox
    bus_op("pre_fill", 1'b1, 16'h0031, 8'h11, 0, 0, 0,
           1, 1, '0, 0);
    bus_op("ack_cap", 1'b1, 16'h0031, 8'h99, 0, 0, 0,
           1, 1, 4'b0010, 4);
    chk("ack_cap full", full[0][1], 1);
    chk("ack_cap ovr", ovr[0][1], 0);
    chk("ack_cap data", rxd[0][15:8], 8'h99);
    chk("noack_cap ovr", ovr[1][1], 1);

    for (int r = 0; r < 50; r++) begin
      logic [15:0] a;
      bit wr, m1l, mql, both;
      case ($urandom_range(0, 3))
        0: a = 16'h002E + 16'($urandom_range(0, 7));
        1: a = {8'($urandom), 8'h2E + 8'($urandom_range(0, 7))};
        2: a = 16'($urandom);
        default: a = 16'h0030 + 16'($urandom_range(0, 3));
      endcase
      wr   = 1'($urandom);
      m1l  = ($urandom_range(0, 9) == 0);
      mql  = ($urandom_range(0, 9) == 0);
      both = ($urandom_range(0, 9) == 0);
      tx   = 32'($urandom);
      bus_op($sformatf("rnd%0d", r), wr, a, 8'($urandom),
             m1l, mql, both,
             hit_port(0, a, m1l, mql, both),
             hit_port(1, a, m1l, mql, both), '0, 0);
      if ($urandom_range(0, 2) == 0) begin
        ack_ports(4'($urandom), 4'($urandom));
        check_mbox($sformatf("rnd_ack%0d", r));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/z80_io_port_bank.md
Name: z80_io_port_bank

Overview:
- Parametrised Z80 I/O peripheral; successor to the single fixed-address I/O latch.
- Decodes a contiguous window of NUM_PORTS I/O addresses starting at BASE_ADDR, with either 8- or 16-bit decode.
- Synchronises the asynchronous Z80 strobes into the FPGA clock and drives the external bus transceiver (enable and direction).
- Fabric side gets per-port readback registers, one-cycle strobes, and a mailbox full/overrun flag per port for Z80 writes.

Parameters:
- BASE_ADDR, 16'h0030, first decoded I/O address.
- NUM_PORTS, 4, number of consecutive ports (1..16).
- ADDR_BITS, 16, decode width: 8 compares z80_a[7:0] only; 16 compares the full bus.
- SYNC_STAGES, 2, flip-flop stages on each Z80 strobe (min 2).

Ports:
- clk  in  1  fabric clock (SB_HFOSC domain)
- rst  in  1  asynchronous reset, active-high
- z80_a  in  16  Z80 address bus
- z80_d_in  in  8  data from transceiver
- z80_d_out  out  8  data to transceiver
- z80_d_oe  out  1  transceiver enable, active-high
- z80_d_dir  out  1  transceiver direction: 1 = into FPGA (D_IN), 0 = out to Z80 (D_OUT)
- z80_rd_n, z80_wr_n, z80_m1_n, z80_iorq_n, z80_mreq_n  in  1 each  Z80 strobes, active-low, asynchronous
- host_tx_data  in  8*NUM_PORTS  readback value per port; port k at [8k+7:8k]
- host_rx_data  out  8*NUM_PORTS  last Z80-written byte per port
- rd_pulse  out  NUM_PORTS  one-cycle pulse per completed Z80 read start
- wr_pulse  out  NUM_PORTS  one-cycle pulse when a write byte is captured
- rx_full  out  NUM_PORTS  mailbox holds an unacknowledged byte
- rx_ack  in  NUM_PORTS  fabric consumes the mailbox byte
- overrun  out  NUM_PORTS  sticky: write landed while rx_full was set

Behaviour:
- Reset values:
  - z80_d_oe = 0, z80_d_dir = 1, z80_d_out = 0
  - all host_rx_data = 0, all pulses = 0, rx_full = 0, overrun = 0
  - synchroniser chains preset to 1 (inactive); FSM in IDLE
- Reset is asynchronous. Asserting it mid-cycle releases the bus in the same instant, with no clock needed.
- Strobes pass through SYNC_STAGES flops. Address and data are sampled directly; they are stable once the synchronised strobe is seen.
- Decode (hit) requires all of the following on the synchronised strobes:
  - iorq_n = 0, mreq_n = 1, m1_n = 1
  - exactly one of rd_n/wr_n = 0
  - addr in [BASE_ADDR, BASE_ADDR+NUM_PORTS), where addr = z80_a[ADDR_BITS-1:0] and BASE_ADDR is truncated to ADDR_BITS
  - port index = addr − BASE_ADDR, computed in ADDR_BITS arithmetic with no wrap: a window crossing 2^ADDR_BITS is truncated
- Never a hit:
  - interrupt acknowledge (m1_n = 0 with iorq_n = 0)
  - rd_n and wr_n both low
- FSM states: IDLE, RD_DRIVE, WR_CAP, WR_HOLD.
  - IDLE, read hit → RD_DRIVE:
    - latch index; z80_d_out <= host_tx_data[index] (snapshot, held constant for the whole cycle)
    - z80_d_dir <= 0, z80_d_oe <= 1
    - rd_pulse[index] = 1 for one cycle
  - RD_DRIVE → IDLE when the synchronised rd_n = 1 or iorq_n = 1. On the exit edge z80_d_oe <= 0 and z80_d_dir <= 1.
  - IDLE, write hit → WR_CAP: latch index; z80_d_oe <= 1, z80_d_dir stays 1.
  - WR_CAP → WR_HOLD after one cycle (transceiver settle). On this edge:
    - host_rx_data[index] <= z80_d_in
    - wr_pulse[index] = 1
    - rx_full[index] <= 1
    - overrun[index] <= 1 if rx_full[index] was already 1 and rx_ack[index] = 0 that cycle
  - WR_HOLD → IDLE when the synchronised wr_n = 1 or iorq_n = 1; z80_d_oe <= 0.
- Exactly one bus cycle is serviced per strobe assertion. No re-trigger until the strobe is released.
- rx_ack[k] clears rx_full[k] and overrun[k] next edge.
  - If the ack coincides with the capture edge for port k, capture wins: rx_full stays 1 and overrun is not set.
- Port-level latency: decode-to-drive equals SYNC_STAGES+1 clk edges after the strobe falls. Bus release takes SYNC_STAGES+1 edges after the strobe rises.
- z80_d_dir = 0 is allowed only in RD_DRIVE. This is an invariant that must never be violated.

Test Plan:
- Reset, then idle bus → z80_d_oe=0, z80_d_dir=1, rx_full=0, all pulses 0.
- BASE_ADDR=16'h0030, host_tx_data port2=8'hA5; Z80 IN from 0x0032 → z80_d_dir=0 and z80_d_out=8'hA5 within 3 clk; rd_pulse[2] pulses once; dir returns to 1 three clk after rd_n rises.
- OUT 0x0031 with data 8'h3C → host_rx_data port1=8'h3C, wr_pulse[1] single pulse, rx_full[1]=1; second OUT 8'h7E without ack → overrun[1]=1, data=8'h7E; rx_ack[1] → both flags clear.
- Addresses 0x002F, 0x0034, 0x1230 with ADDR_BITS=16 → no response. With ADDR_BITS=8, 0x1230 → hits port 0.
- Interrupt acknowledge (m1_n=0, iorq_n=0, addr 0x0030), and a cycle with rd_n and wr_n both low → z80_d_oe stays 0 throughout.
- rst asserted during RD_DRIVE → z80_d_dir=1 and z80_d_oe=0 immediately, no clock edge required; a write with rx_ack on the same capture edge → rx_full=1, overrun=0.
